uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clocks per serial bit (i_Clock freq / baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the transmit buffer entry count; power of two, minimum 2; used only when UART_TX_FIFO_EN is defined.
REQ-003 SHALL have port i_Clock  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port i_Reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_Tx_DV  input  1  one-cycle request to send i_Tx_Byte.
REQ-006 SHALL have port i_Tx_Byte  input  16  data word; only bits [7:0] are transmitted, bits [15:8] are ignored.
REQ-007 SHALL have port o_Tx_Ready  output  1  high when a request is accepted this cycle.
REQ-008 SHALL have port o_Tx_Active  output  1  high while a frame (start, data or stop bit) is on the line.
REQ-009 SHALL have port o_Tx_Serial  output  1  serial line; idle high.
REQ-010 SHALL have port o_Tx_Done  output  1  one-cycle pulse after each stop bit completes.

Function
REQ-011 SHALL send frames of 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-012 SHALL hold each bit on o_Tx_Serial for exactly CLKS_PER_BIT clocks; one frame = 10*CLKS_PER_BIT clocks.
REQ-013 SHALL use states IDLE, START, DATA, STOP, CLEANUP; every other encoding goes to IDLE.
REQ-014 SHALL take these transitions: IDLE->START when a byte is pending; START->DATA after CLKS_PER_BIT clocks; DATA->DATA per bit until bit index 7 completes, then ->STOP; STOP->CLEANUP after CLKS_PER_BIT clocks; CLEANUP->IDLE after 1 clock.
REQ-015 SHALL drive o_Tx_Serial low on the rising edge that follows acceptance of a request while in IDLE, giving one-clock latency.
REQ-016 SHALL register the byte when the request is accepted; changes on i_Tx_Byte afterwards SHALL NOT affect the frame.
REQ-017 SHALL drive o_Tx_Done high only for the single CLEANUP cycle.
REQ-018 SHALL hold o_Tx_Active high in START, DATA and STOP, and low otherwise.
REQ-019 SHALL keep the line high for at least 2 clocks between frames (the CLEANUP and IDLE cycles).
REQ-020 SHALL size its bit counter to hold CLKS_PER_BIT-1; it resets to 0 at each bit boundary and never wraps within a bit.

Reset
REQ-021 SHALL, on i_Reset high, asynchronously force: state IDLE, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, counters 0, buffer empty.
REQ-022 SHALL abort any frame in progress on reset mid-frame, with the line returning high immediately; no Done pulse for the aborted frame.
REQ-023 SHALL have o_Tx_Ready equal 1 in the first cycle after reset release.

Configuration
REQ-024 SHALL, without macro UART_TX_FIFO_EN: o_Tx_Ready = (state == IDLE); i_Tx_DV while not ready is silently dropped.
REQ-025 SHALL, with UART_TX_FIFO_EN:
- buffer up to FIFO_DEPTH bytes; o_Tx_Ready = not full.
- IDLE pops the head entry when the buffer is non-empty.
- A push while full is dropped.
- A push and pop in the same cycle when full SHALL be accepted, leaving occupancy unchanged.
- Read and write pointers wrap modulo FIFO_DEPTH.
- A push into an empty buffer while IDLE starts the frame with the same one-clock latency as REQ-015.

Structure
REQ-026 SHALL take its state encodings (IDLE..CLEANUP) and the default CLKS_PER_BIT from shared package uart_pkg, which uart_rx also uses.
REQ-027 SHALL implement the buffer as sub-module uart_tx_fifo (synchronous, async active-high reset, full/empty flags), instantiated only under UART_TX_FIFO_EN.

Verification (CLKS_PER_BIT=4)
REQ-028 SHALL cover: i_Tx_Byte=0x0055 pulsed at cycle 0 -> serial 0,1,0,1,0,1,0,1,0,1, each 4 clocks, starting at cycle 1; o_Tx_Done high at cycle 41 only.
REQ-029 SHALL cover: i_Tx_Byte=0xAB3C -> data bits 0,0,1,1,1,1,0,0 (0x3C, LSB first); upper byte has no effect.
REQ-030 SHALL cover, without FIFO: second i_Tx_DV (0x00FF) at cycle 10 during frame 0x0055 -> dropped; o_Tx_Ready=0 at cycle 10; only one frame sent.
REQ-031 SHALL cover, with FIFO, FIFO_DEPTH=4: five consecutive pushes 0x01..0x05 -> 0x01 popped at once, 0x02..0x05 buffered, then five frames in order, each separated by 2 idle-high clocks; five Done pulses.
REQ-032 SHALL cover, with FIFO: a sixth push while full -> dropped with o_Tx_Ready=0; a push in the same cycle as a pop -> accepted.
REQ-033 SHALL cover: i_Reset asserted at cycle 20 mid-frame -> o_Tx_Serial=1 and o_Tx_Active=0 immediately; no Done pulse; a new request after release sends a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit timing.
// Both uart_tx and uart_rx import this package.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 868;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit buffer (power-of-two depth) with full/empty flags.
// When full, a push is accepted only if a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. Optional transmit buffer enabled by macro UART_TX_FIFO_EN;
// without it, requests arriving outside IDLE are dropped.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Tx_DV,
  input  logic [15:0] i_Tx_Byte,
  output logic        o_Tx_Ready,
  output logic        o_Tx_Active,
  output logic        o_Tx_Serial,
  output logic        o_Tx_Done
);

  localparam int            CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  uart_state_t   state, state_n;
  logic [CW-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    tx_data, next_byte;
  logic          start_req, bit_end;
  logic          unused_bits;

  assign unused_bits = ^i_Tx_Byte[15:8];
  assign bit_end     = (clk_cnt == CNT_MAX);

`ifdef UART_TX_FIFO_EN
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;

  // A request into an empty buffer while IDLE bypasses it to keep one-clock latency.
  assign fifo_pop   = (state == IDLE) && !fifo_empty;
  assign fifo_push  = i_Tx_DV && !((state == IDLE) && fifo_empty);
  assign start_req  = (state == IDLE) && (!fifo_empty || i_Tx_DV);
  assign next_byte  = fifo_empty ? i_Tx_Byte[7:0] : fifo_dout;
  assign o_Tx_Ready = !fifo_full || fifo_pop;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk   (i_Clock),
    .rst   (i_Reset),
    .push  (fifo_push),
    .din   (i_Tx_Byte[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
`else
  localparam int unused_depth = FIFO_DEPTH;

  assign start_req  = (state == IDLE) && i_Tx_DV;
  assign next_byte  = i_Tx_Byte[7:0];
  assign o_Tx_Ready = (state == IDLE);
`endif

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      tx_data <= '0;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_idx <= bit_idx_n;
      if (start_req) tx_data <= next_byte;
    end
  end

  always_comb begin
    state_n     = state;
    clk_cnt_n   = clk_cnt;
    bit_idx_n   = bit_idx;
    o_Tx_Serial = 1'b1;
    o_Tx_Active = 1'b0;
    o_Tx_Done   = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_n = '0;
        bit_idx_n = '0;
        if (start_req) state_n = START;
      end
      START: begin
        o_Tx_Serial = 1'b0;
        o_Tx_Active = 1'b1;
        if (bit_end) begin
          clk_cnt_n = '0;
          state_n   = DATA;
        end else begin
          clk_cnt_n = clk_cnt + CW'(1);
        end
      end
      DATA: begin
        o_Tx_Serial = tx_data[bit_idx];
        o_Tx_Active = 1'b1;
        if (bit_end) begin
          clk_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            bit_idx_n = '0;
            state_n   = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_n = clk_cnt + CW'(1);
        end
      end
      STOP: begin
        o_Tx_Active = 1'b1;
        if (bit_end) begin
          clk_cnt_n = '0;
          state_n   = CLEANUP;
        end else begin
          clk_cnt_n = clk_cnt + CW'(1);
        end
      end
      CLEANUP: begin
        o_Tx_Done = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
